// File: rtl/jk_bank_driver_if.sv
// Target handshake and J/K excitation bundle between control logic and jk_bank_driver.
// The q/err readback pair exists only when JK_READBACK_CHK_EN is defined.
interface jk_bank_driver_if #(
  parameter int WIDTH = 4
);
  // Handshake: a target transfers on a rising edge where tgt_valid && tgt_ready;
  // tgt is only sampled on that edge and tgt_valid without tgt_ready is ignored.
  logic [WIDTH-1:0] tgt;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] shadow;
  logic             busy;
  logic             done;
`ifdef JK_READBACK_CHK_EN
  logic [WIDTH-1:0] q;
  logic             err;
`endif

  modport master (
    output tgt, tgt_valid,
    input  tgt_ready, j, k, shadow, busy, done
`ifdef JK_READBACK_CHK_EN
    , output q
    , input  err
`endif
  );

  modport slave (
    input  tgt, tgt_valid,
    output tgt_ready, j, k, shadow, busy, done
`ifdef JK_READBACK_CHK_EN
    , input  q
    , output err
`endif
  );
endinterface

// File: rtl/jk_bank_driver.sv
// Drives a JK flip-flop bank to a target word, parallel or one bit per cycle.
// Optional readback compare of the bank against the shadow: JK_READBACK_CHK_EN.
module jk_bank_driver #(
  parameter int WIDTH      = 4,
  parameter int SERIAL     = 0,
  parameter int USE_TOGGLE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  jk_bank_driver_if.slave   bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] remain;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] sel_base;
`ifdef JK_READBACK_CHK_EN
  logic             err_q, err_d;
`endif

  // Serial mode isolates the lowest set bit of the difference.
  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] d);
    if (SERIAL != 0) pick = d & (~d + WIDTH'(1));
    else             pick = d;
  endfunction

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    sel      = '0;
    sel_base = shadow_q;
    // Shadow follows the JK equation on the same edge the bank samples j/k.
    shadow_d = (j_q & ~shadow_q) | (~k_q & shadow_q);
    remain   = tgt_q ^ shadow_d;
`ifdef JK_READBACK_CHK_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.tgt_valid) begin
          tgt_d    = bus.tgt;
          sel      = pick(bus.tgt ^ shadow_q);
          sel_base = shadow_q;
          state_d  = DRIVE;
`ifdef JK_READBACK_CHK_EN
          err_d    = 1'b0;
`endif
        end
      end
      DRIVE: begin
        if ((SERIAL != 0) && (remain != '0)) begin
          sel      = pick(remain);
          sel_base = shadow_d;
        end else begin
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef JK_READBACK_CHK_EN
        if (bus.q != shadow_q) err_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    // A selected bit differs from the shadow, so ~sel_base marks a 0->1 change.
    if (USE_TOGGLE != 0) begin
      j_d = sel;
      k_d = sel;
    end else begin
      j_d = sel & ~sel_base;
      k_d = sel & sel_base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef JK_READBACK_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign bus.err = err_q;
`endif

  assign bus.tgt_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.shadow    = shadow_q;
  assign state_dbg     = state_q;

  a_no_jk_conflict: assert property (@(posedge clk) disable iff (!rst_n)
    (USE_TOGGLE != 0) || ((j_q & k_q) == '0));
  a_quiet_outside_drive: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DRIVE) || ((j_q | k_q) == '0));

endmodule
